// File: rtl/vga_ram_wr_arb.sv
// vga_ram_wr_arb: single-port write arbiter for the VGA pixel RAM.
// A pixel-write requester (valid/ready) shares the RAM write port with a
// whole-RAM fill engine. The fill engine is compiled in only when the
// macro VGA_RAM_WR_ARB_FILL_EN is defined; otherwise fill_start/fill_color
// are ignored and the requester owns the port permanently.
module vga_ram_wr_arb #(
  parameter int DEPTH = 12288,
  parameter int AW    = 14,
  parameter int DW    = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_data,
  input  logic          fill_start,
  input  logic [DW-1:0] fill_color,
  output logic          fill_busy,
  output logic          fill_done,
  output logic          ram_wen,
  output logic [AW-1:0] ram_waddr,
  output logic [DW-1:0] ram_wdata,
  output logic          err_oob
);

  // One extra bit so DEPTH itself is representable for the range check.
  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic          ready_en;
  logic          xfer;
  logic          addr_ok;
  logic          fill_wr;
  logic [AW-1:0] fill_addr;
  logic [DW-1:0] fill_data;

  assign xfer    = req_valid && req_ready;
  assign addr_ok = ({1'b0, req_addr} < DEPTH_W);

  // Keeps req_ready low during reset and raises it on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

`ifdef VGA_RAM_WR_ARB_FILL_EN
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] fill_cnt;
  logic [DW-1:0] fill_col;
  logic          done_q;

  // Fill sequencer: latch colour on start, walk 0..DEPTH-1, then one DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      fill_cnt <= '0;
      fill_col <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fill_start) begin
            state    <= ST_FILL;
            fill_cnt <= '0;
            fill_col <= fill_color;
          end
        end
        ST_FILL: begin
          if (fill_cnt == LAST_ADDR) state <= ST_DONE;
          else                       fill_cnt <= fill_cnt + 1'b1;
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          done_q <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = ready_en && (state == ST_IDLE);
  assign fill_busy = (state != ST_IDLE);
  assign fill_done = done_q;
  assign fill_wr   = (state == ST_FILL);
  assign fill_addr = fill_cnt;
  assign fill_data = fill_col;
`else
  logic unused_fill;

  assign unused_fill = ^{fill_start, fill_color};
  assign req_ready   = ready_en;
  assign fill_busy   = 1'b0;
  assign fill_done   = 1'b0;
  assign fill_wr     = 1'b0;
  assign fill_addr   = '0;
  assign fill_data   = '0;
`endif

  // Registered RAM port: fill writes win; otherwise an accepted request is
  // written one cycle later, or dropped with err_oob when out of range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_wen   <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= '0;
      err_oob   <= 1'b0;
    end else begin
      ram_wen <= 1'b0;
      err_oob <= 1'b0;
      if (fill_wr) begin
        ram_wen   <= 1'b1;
        ram_waddr <= fill_addr;
        ram_wdata <= fill_data;
      end else if (xfer) begin
        ram_wen   <= addr_ok;
        ram_waddr <= req_addr;
        ram_wdata <= req_data;
        err_oob   <= !addr_ok;
      end
    end
  end

endmodule

// File: tb/tb_vga_ram_wr_arb.sv
// tb_vga_ram_wr_arb: directed self-checking bench for vga_ram_wr_arb.
// Fill-engine scenarios run when VGA_RAM_WR_ARB_FILL_EN is defined; the
// default build checks that the fill inputs are ignored instead.
module tb_vga_ram_wr_arb;

  localparam int DEPTH = 12288;
  localparam int AW    = 14;
  localparam int DW    = 12;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          fill_start;
  logic [DW-1:0] fill_color;
  logic          fill_busy;
  logic          fill_done;
  logic          ram_wen;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic          err_oob;

  int checks = 0;
  int errors = 0;

  vga_ram_wr_arb #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .fill_start (fill_start),
    .fill_color (fill_color),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .ram_wen    (ram_wen),
    .ram_waddr  (ram_waddr),
    .ram_wdata  (ram_wdata),
    .err_oob    (err_oob)
  );

  // 100 MHz free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Linear directed sequence.
  initial begin
    logic [AW-1:0] exp_addr;
    int            wen_cnt;
    int            bad;
    logic          done_seen;
    logic          busy_at_done;
    logic          ready_at_done;

    req_valid  = 1'b0;
    req_addr   = '0;
    req_data   = '0;
    fill_start = 1'b0;
    fill_color = '0;
    rst_n      = 1'b1;
    #1 rst_n   = 1'b0;

    $display("[TB] reset");
    step();
    step();
    check("rst_ram_wen",   ram_wen,   0);
    check("rst_ram_waddr", ram_waddr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_fill_busy", fill_busy, 0);
    check("rst_fill_done", fill_done, 0);
    check("rst_err_oob",   err_oob,   0);
    check("rst_req_ready", req_ready, 0);
    rst_n = 1'b1;
    #1;
    check("rel_req_ready_before_edge", req_ready, 0);
    step();
    check("rel_req_ready_after_edge", req_ready, 1);

    $display("[TB] single write");
    req_valid = 1'b1; req_addr = 14'h0010; req_data = 12'hF00;
    step();
    req_valid = 1'b0;
    check("wr_ram_wen",   ram_wen,   1);
    check("wr_ram_waddr", ram_waddr, 14'h0010);
    check("wr_ram_wdata", ram_wdata, 12'hF00);
    check("wr_err_oob",   err_oob,   0);
    step();
    check("wr_idle_ram_wen", ram_wen, 0);

    $display("[TB] out-of-range and boundary requests");
    req_valid = 1'b1; req_addr = 14'd12288; req_data = 12'hABC;
    step();
    req_valid = 1'b0;
    check("oob_ram_wen", ram_wen, 0);
    check("oob_err",     err_oob, 1);
    step();
    check("oob_err_pulse_end", err_oob, 0);
    req_valid = 1'b1; req_addr = 14'd12287; req_data = 12'h0C3;
    step();
    req_valid = 1'b0;
    check("last_ram_wen",   ram_wen,   1);
    check("last_ram_waddr", ram_waddr, 14'd12287);
    check("last_err_oob",   err_oob,   0);
    step();

`ifdef VGA_RAM_WR_ARB_FILL_EN
    $display("[TB] full fill with request pending");
    fill_start = 1'b1; fill_color = 12'h0A5;
    step();
    fill_start = 1'b0;
    check("fill_busy_start",  fill_busy, 1);
    check("fill_ready_start", req_ready, 0);
    check("fill_wen_start",   ram_wen,   0);
    req_valid = 1'b1; req_addr = 14'd5; req_data = 12'h3C3;
    exp_addr = '0; wen_cnt = 0; bad = 0;
    done_seen = 1'b0; busy_at_done = 1'b1; ready_at_done = 1'b0;
    for (int i = 0; i < 13000; i++) begin
      if (i == 50) begin fill_start = 1'b1; fill_color = 12'hFFF; end
      if (i == 51) fill_start = 1'b0;
      step();
      if (fill_done) begin
        done_seen = 1'b1; busy_at_done = fill_busy; ready_at_done = req_ready;
        break;
      end
      if (ram_wen) begin
        if (ram_waddr !== exp_addr || ram_wdata !== 12'h0A5 || fill_busy !== 1'b1 || req_ready !== 1'b0)
          bad++;
        exp_addr++;
        wen_cnt++;
      end else if (wen_cnt < DEPTH) begin
        bad++;
      end
    end
    check("fill_done_seen",     done_seen,     1);
    check("fill_write_count",   wen_cnt,       DEPTH);
    check("fill_bad_cycles",    bad,           0);
    check("fill_busy_at_done",  busy_at_done,  0);
    check("fill_ready_at_done", ready_at_done, 1);
    step();
    req_valid = 1'b0;
    check("fill_done_pulse_end", fill_done, 0);
    check("pend_ram_wen",   ram_wen,   1);
    check("pend_ram_waddr", ram_waddr, 14'd5);
    check("pend_ram_wdata", ram_wdata, 12'h3C3);
    step();
    check("pend_idle_wen", ram_wen, 0);

    $display("[TB] simultaneous start and write");
    fill_start = 1'b1; fill_color = 12'h555;
    req_valid = 1'b1; req_addr = 14'd3; req_data = 12'hFFF;
    check("sim_ready", req_ready, 1);
    step();
    fill_start = 1'b0; req_valid = 1'b0;
    check("sim_req_wen",   ram_wen,   1);
    check("sim_req_waddr", ram_waddr, 14'd3);
    check("sim_req_wdata", ram_wdata, 12'hFFF);
    check("sim_busy",      fill_busy, 1);
    step();
    check("sim_fill0_waddr", ram_waddr, 14'd0);
    check("sim_fill0_wdata", ram_wdata, 12'h555);
    step(); step(); step();
    check("sim_fill3_wen",   ram_wen,   1);
    check("sim_fill3_waddr", ram_waddr, 14'd3);
    check("sim_fill3_wdata", ram_wdata, 12'h555);
    done_seen = 1'b0;
    for (int i = 0; i < 13000; i++) begin
      step();
      if (fill_done) begin done_seen = 1'b1; break; end
    end
    check("sim_done_seen", done_seen, 1);
    step();

    $display("[TB] reset mid-fill");
    fill_start = 1'b1; fill_color = 12'h0F0;
    step();
    fill_start = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (ram_wen && ram_waddr == 14'd100) begin done_seen = 1'b1; break; end
    end
    check("mid_reached_100", done_seen, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_wen",   ram_wen,   0);
    check("mid_rst_busy",  fill_busy, 0);
    check("mid_rst_ready", req_ready, 0);
    step(); step();
    check("mid_rst_hold_wen", ram_wen, 0);
    rst_n = 1'b1;
    #1;
    check("mid_rel_ready_before", req_ready, 0);
    step();
    check("mid_rel_ready_after", req_ready, 1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ram_wen !== 1'b0 || fill_done !== 1'b0 || fill_busy !== 1'b0) bad++;
    end
    check("mid_no_activity", bad, 0);
`else
    $display("[TB] fill disabled: inputs ignored");
    fill_start = 1'b1; fill_color = 12'h0A5;
    step();
    fill_start = 1'b0;
    check("nofill_busy",  fill_busy, 0);
    check("nofill_wen",   ram_wen,   0);
    check("nofill_ready", req_ready, 1);
    fill_start = 1'b1; req_valid = 1'b1; req_addr = 14'd3; req_data = 12'hFFF;
    step();
    fill_start = 1'b0; req_valid = 1'b0;
    check("nofill_sim_wen",   ram_wen,   1);
    check("nofill_sim_waddr", ram_waddr, 14'd3);
    check("nofill_sim_wdata", ram_wdata, 12'hFFF);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ram_wen !== 1'b0 || fill_done !== 1'b0 || fill_busy !== 1'b0 || req_ready !== 1'b1) bad++;
    end
    check("nofill_quiet", bad, 0);
    req_valid = 1'b1; req_addr = 14'd7; req_data = 12'h111;
    step();
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("nofill_rst_wen",   ram_wen,   0);
    check("nofill_rst_ready", req_ready, 0);
    step();
    rst_n = 1'b1;
    #1;
    check("nofill_rel_ready_before", req_ready, 0);
    step();
    check("nofill_rel_ready_after", req_ready, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
